// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst sequencer for a single-port memory with a 2-entry read response buffer
module mem_burst_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    output logic                  wr_done,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam logic [1:0] IDLE = 2'd0, WR = 2'd1, RD = 2'd2, DRAIN = 2'd3;
    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  len_q, beat_cnt;
    logic                  inflight, inflight_last;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic                  buf_last [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            occ;
    logic                  push, pop, last_beat;
    assign req_ready = state == IDLE;
    assign wd_ready  = state == WR;
    assign mem_wr_en = wd_ready && wd_valid;
    // credit check: an issued read always has a free buffer slot when it lands
    assign mem_rd_en = state == RD && (occ + 2'(inflight)) < 2'd2;
    assign mem_addr  = cur_addr;
    assign mem_wdata = wd_data;
    assign last_beat = beat_cnt == len_q;
    assign push      = inflight;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = occ != 2'd0;
    assign rsp_data  = buf_data[rd_ptr];
    assign rsp_last  = buf_last[rd_ptr];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cur_addr      <= '0;
            len_q         <= '0;
            beat_cnt      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            occ           <= 2'd0;
            wr_done       <= 1'b0;
        end else begin
            wr_done  <= 1'b0;
            inflight <= mem_rd_en;
            if (mem_rd_en) inflight_last <= last_beat;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(push) - 2'(pop);
            case (state)
                IDLE: if (req_valid) begin
                    cur_addr <= req_addr;
                    len_q    <= req_len;
                    beat_cnt <= '0;
                    state    <= req_write ? WR : RD;
                end
                WR: if (wd_valid) begin
                    cur_addr <= cur_addr + ADDR_WIDTH'(1);
                    beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                    if (last_beat) begin
                        state   <= IDLE;
                        wr_done <= 1'b1;
                    end
                end
                RD: if (mem_rd_en) begin
                    cur_addr <= cur_addr + ADDR_WIDTH'(1);
                    beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                    if (last_beat) state <= DRAIN;
                end
                DRAIN: if (!inflight && occ == 2'd0) state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= mem_rdata;
            buf_last[wr_ptr] <= inflight_last;
        end
    end
endmodule
